// File: rtl/downcnt_pkg.sv
// Shared types and constants for the down_counter_timer block.
// Optional feature macro used across the block: DOWNCNT_IRQ_EN (sticky irq output).
package downcnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } dc_state_t;

    localparam int DC_DEFAULT_WIDTH = 8;

    // A start request is only meaningful from a parked state (IDLE or EXPIRED).
    function automatic logic dc_can_start(input dc_state_t st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down_counter_timer.
// With DOWNCNT_IRQ_EN defined the bundle also carries irq_clr/irq.
interface down_counter_timer_if
    import downcnt_pkg::*;
#(
    parameter int WIDTH = DC_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] d_in;
    logic             set;
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q_out;
    logic             tc;
    logic             busy;
`ifdef DOWNCNT_IRQ_EN
    logic             irq_clr;
    logic             irq;
`endif

`ifdef DOWNCNT_IRQ_EN
    modport master (
        output d_in, set, start, stop, en, auto_reload, irq_clr,
        input  q_out, tc, busy, irq
    );

    modport slave (
        input  d_in, set, start, stop, en, auto_reload, irq_clr,
        output q_out, tc, busy, irq
    );
`else
    modport master (
        output d_in, set, start, stop, en, auto_reload,
        input  q_out, tc, busy
    );

    modport slave (
        input  d_in, set, start, stop, en, auto_reload,
        output q_out, tc, busy
    );
`endif

endinterface

// File: rtl/downcnt_fsm.sv
// Control FSM of the down_counter_timer: holds the IDLE/RUN/EXPIRED state and
// resolves the per-cycle priority set > stop > start > en into datapath strobes.
module downcnt_fsm
    import downcnt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic start,
    input  logic stop,
    input  logic en,
    input  logic auto_reload,
    input  logic count_zero,
    input  logic count_one,
    input  logic reload_zero,
    output logic load,
    output logic dec,
    output logic reload,
    output logic expire,
    output logic busy
);

    dc_state_t state_r;
    dc_state_t state_cur_s;
    dc_state_t state_nxt_s;
    logic      busy_r;

    // Next-state and strobe decode; an illegal state code is treated as IDLE.
    always_comb begin
        state_cur_s = ST_IDLE;
        state_nxt_s = ST_IDLE;
        load        = 1'b0;
        dec         = 1'b0;
        reload      = 1'b0;
        expire      = 1'b0;

        case (state_r)
            ST_IDLE:    state_cur_s = ST_IDLE;
            ST_RUN:     state_cur_s = ST_RUN;
            ST_EXPIRED: state_cur_s = ST_EXPIRED;
            default:    state_cur_s = ST_IDLE;
        endcase

        state_nxt_s = state_cur_s;

        if (set) begin
            // Load aborts anything in flight and parks the timer.
            load        = 1'b1;
            state_nxt_s = ST_IDLE;
        end else if (stop) begin
            // Stop freezes the count; it also masks a same-cycle expiry.
            if (state_cur_s == ST_RUN) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = state_cur_s;
            end
        end else if (start && dc_can_start(state_cur_s)) begin
            // Starting with nothing to count is ignored.
            if (!count_zero) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = state_cur_s;
            end
        end else if ((state_cur_s == ST_RUN) && en) begin
            if (count_one) begin
                expire = 1'b1;
                // A zero reload value would spin forever, so it expires instead.
                if (auto_reload && !reload_zero) begin
                    reload      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_EXPIRED;
                end
            end else if (!count_zero) begin
                dec         = 1'b1;
                state_nxt_s = ST_RUN;
            end else begin
                // Zero count while running cannot happen normally; recover to IDLE.
                state_nxt_s = ST_IDLE;
            end
        end else begin
            state_nxt_s = state_cur_s;
        end
    end

    // State register; busy is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-cycle terminal-count pulse and optional
// auto-reload. Define DOWNCNT_IRQ_EN to add a sticky irq output with irq_clr.
module down_counter_timer
    import downcnt_pkg::*;
#(
    parameter int WIDTH = DC_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    down_counter_timer_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_q_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_r;
    logic             load_s;
    logic             dec_s;
    logic             reload_s;
    logic             expire_s;
    logic             busy_s;

    downcnt_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .set         (bus.set),
        .start       (bus.start),
        .stop        (bus.stop),
        .en          (bus.en),
        .auto_reload (bus.auto_reload),
        .count_zero  (count_r == ZERO),
        .count_one   (count_r == ONE),
        .reload_zero (reload_q_r == ZERO),
        .load        (load_s),
        .dec         (dec_s),
        .reload      (reload_s),
        .expire      (expire_s),
        .busy        (busy_s)
    );

    // Next count from the FSM strobes; a non-reloading expiry lands on zero.
    always_comb begin
        count_nxt_s = count_r;
        if (load_s) begin
            count_nxt_s = bus.d_in;
        end else if (reload_s) begin
            count_nxt_s = reload_q_r;
        end else if (expire_s) begin
            count_nxt_s = ZERO;
        end else if (dec_s) begin
            count_nxt_s = count_r - ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count, reload value and terminal-count pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= ZERO;
            reload_q_r <= ZERO;
            tc_r       <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= expire_s;
            if (load_s) begin
                reload_q_r <= bus.d_in;
            end else begin
                reload_q_r <= reload_q_r;
            end
        end
    end

    assign bus.q_out = count_r;
    assign bus.tc    = tc_r;
    assign bus.busy  = busy_s;

`ifdef DOWNCNT_IRQ_EN
    logic irq_r;

    // Sticky interrupt: every tc sets it, irq_clr clears it, set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else if (tc_r) begin
            irq_r <= 1'b1;
        end else if (bus.irq_clr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign bus.irq = irq_r;
`endif

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: each driven cycle pushes the
// hand-computed post-edge outputs; a monitor pops and compares after the edge.
module tb_down_counter_timer;
    import downcnt_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    down_counter_timer_if #(.WIDTH(8)) bus ();

    down_counter_timer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       tc;
        logic       busy;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_out(input string nm, input logic [7:0] q, input logic tc,
                             input logic busy, input logic irq);
        logic [10:0] act;
        logic [10:0] req;
`ifdef DOWNCNT_IRQ_EN
        act = {bus.q_out, bus.tc, bus.busy, bus.irq};
        req = {q, tc, busy, irq};
`else
        act = {bus.q_out, bus.tc, bus.busy, 1'b0};
        req = {q, tc, busy, 1'b0};
`endif
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got q=%0d tc=%0b busy=%0b irq=%0b, want q=%0d tc=%0b busy=%0b irq=%0b",
                     nm, act[10:3], act[2], act[1], act[0], req[10:3], req[2], req[1], req[0]);
        end
    endtask

    // Drive one cycle of inputs at negedge and queue the outputs expected after the next posedge.
    task automatic cyc(input string nm, input logic [7:0] d, input logic s, input logic st,
                       input logic sp, input logic e, input logic ar, input logic ic,
                       input logic [7:0] eq, input logic etc, input logic eb, input logic ei);
        exp_t x;
        @(negedge clk);
        bus.d_in        = d;
        bus.set         = s;
        bus.start       = st;
        bus.stop        = sp;
        bus.en          = e;
        bus.auto_reload = ar;
`ifdef DOWNCNT_IRQ_EN
        bus.irq_clr     = ic;
`else
        if (ic) begin
            bus.en = e;
        end
`endif
        x.name = nm;
        x.q    = eq;
        x.tc   = etc;
        x.busy = eb;
        x.irq  = ei;
        sb.push_back(x);
    endtask

    // Monitor: outputs settle just after the edge; compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_out(e.name, e.q, e.tc, e.busy, e.irq);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.d_in        = 8'd0;
        bus.set         = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;
`ifdef DOWNCNT_IRQ_EN
        bus.irq_clr     = 1'b0;
`endif
        #12;
        check_out("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //   name           d     set   start stop  en    ar    ic    q     tc    busy  irq
        // One-shot count of 3 with irq_clr during the tc cycle.
        cyc("t2_set",       8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        cyc("t2_start",     8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0);
        cyc("t2_dec2",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        cyc("t2_dec1",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        cyc("t2_expire",    8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        cyc("t2_clr_in_tc", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        cyc("t2_clr_after", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc("t2_start_zero",8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Auto-reload with period 2, then stop coinciding with expiry.
        cyc("t3_set",       8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0);
        cyc("t3_start",     8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        cyc("t3_c1",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        cyc("t3_c2",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
        cyc("t3_c3",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b1);
        cyc("t3_c4",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1);
        cyc("t3_c5",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b1);
        cyc("t3_c6",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1);
        cyc("t3_c7",        8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b1);
        cyc("t3_stop_exp",  8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
        cyc("t3_clr",       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);

        // Hold with en=0, stop with en=1, resume from held count.
        cyc("t4_set",       8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
        cyc("t4_start",     8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc("t4_hold_en0",  8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc("t4_stop",      8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
        cyc("t4_idle_en",   8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
        cyc("t4_resume",    8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc("t4_dec3",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0);
        cyc("t4_dec2",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0);
        cyc("t4_dec1",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0);
        cyc("t4_expire",    8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        cyc("t4_after",     8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        cyc("t4_clr",       8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

        // Zero period, set-beats-start, set aborting a run.
        cyc("t5_set0",      8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc("t5_start0",    8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc("t5_start0_en", 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc("t5_set_start", 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
        cyc("t5_still_idle",8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
        cyc("t5_start",     8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0);
        cyc("t5_dec4",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0);
        cyc("t5_set_abort", 8'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
        cyc("t5_idle_hold", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);

        // Run down to 5, then pull reset asynchronously.
        cyc("t1_start",     8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0);
        cyc("t1_dec6",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0, 1'b1, 1'b0);
        cyc("t1_dec5",      8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t1_async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("t1_post_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc("t1_post_start",8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
